// File: rtl/line_mem_responder.sv
// Line-granular backing memory. It serves one full-line read or write at a time
// with a fixed access latency and signals completion with a one-cycle gnt pulse.
module line_mem_responder #(
   parameter int unsigned LINE_ADDR_LEN = 2,
   parameter int unsigned ADDR_LEN      = 7,
   parameter int unsigned LATENCY       = 8
) (
   input  logic                clk,
   input  logic                rst,
   output logic                gnt,
   input  logic [ADDR_LEN-1:0] addr,
   input  logic                rd_req,
   output logic [31:0]         rd_line [1 << LINE_ADDR_LEN],
   input  logic                wr_req,
   input  logic [31:0]         wr_line [1 << LINE_ADDR_LEN]
);

   localparam int unsigned LINE_SIZE = 1 << LINE_ADDR_LEN;
   localparam int unsigned DEPTH     = 1 << ADDR_LEN;
   localparam logic [7:0]  CNT_LOAD  = 8'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [7:0]          r_cnt;
   logic [ADDR_LEN-1:0] r_addr;
   logic                r_op_wr;
   logic [31:0]         r_wdata   [LINE_SIZE];
   logic [31:0]         r_rd_line [LINE_SIZE];
   logic [31:0]         r_mem     [DEPTH][LINE_SIZE];
   logic                r_gnt;
   logic                w_req;
   logic                w_accept;
   logic                w_enter_done;

   always_comb begin
      w_next       = r_state;
      w_accept     = 1'b0;
      w_enter_done = 1'b0;
      w_req        = r_op_wr ? wr_req : rd_req;
      case (r_state)
         S_IDLE: begin
            if (rd_req || wr_req) begin
               w_next   = S_BUSY;
               w_accept = 1'b1;
            end
         end
         S_BUSY: begin
            // Dropping the latched op's request aborts, even on the final count
            if (!w_req) begin
               w_next = S_IDLE;
            end else if (r_cnt == '0) begin
               w_next       = S_DONE;
               w_enter_done = 1'b1;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_gnt   <= 1'b0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_op_wr <= 1'b0;
         for (int unsigned w = 0; w < LINE_SIZE; w++) begin
            r_wdata[w]   <= '0;
            r_rd_line[w] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_gnt   <= w_enter_done;
         if (w_accept) begin
            r_addr  <= addr;
            r_op_wr <= wr_req;
            r_cnt   <= CNT_LOAD;
            if (wr_req) begin
               for (int unsigned w = 0; w < LINE_SIZE; w++) r_wdata[w] <= wr_line[w];
            end
         end else if (r_state == S_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - 8'd1;
         end
         if (w_enter_done && !r_op_wr) begin
            for (int unsigned w = 0; w < LINE_SIZE; w++) r_rd_line[w] <= r_mem[r_addr][w];
         end
      end
   end

   // Storage is not reset; commits only happen on entry to DONE, which rst prevents
   always_ff @(posedge clk) begin
      if (w_enter_done && r_op_wr) begin
         for (int unsigned w = 0; w < LINE_SIZE; w++) r_mem[r_addr][w] <= r_wdata[w];
      end
   end

   assign gnt     = r_gnt;
   assign rd_line = r_rd_line;

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboarded random/directed bench for line_mem_responder against a line-array
// reference model; expected gnt edge and rd_line are queued at issue time.
module tb_line_mem_responder;

   localparam int LS  = 4;
   localparam int AL  = 7;
   localparam int LAT = 8;

   typedef logic [LS-1:0][31:0] line_t;
   typedef struct {
      int unsigned done_edge;
      line_t       rd;
   } exp_t;

   logic          clk    = 1'b0;
   logic          rst    = 1'b1;
   logic          gnt;
   logic [AL-1:0] addr   = '0;
   logic          rd_req = 1'b0;
   logic          wr_req = 1'b0;
   logic [31:0]   rd_line [LS];
   logic [31:0]   wr_line [LS];

   line_mem_responder #(
      .LINE_ADDR_LEN(2),
      .ADDR_LEN     (AL),
      .LATENCY      (LAT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .gnt    (gnt),
      .addr   (addr),
      .rd_req (rd_req),
      .rd_line(rd_line),
      .wr_req (wr_req),
      .wr_line(wr_line)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t  sb[$];
   line_t mdl_mem [1 << AL];
   line_t mdl_rd;
   int    checks   = 0;
   int    failures = 0;
   logic  prev_gnt = 1'b0;

   function automatic line_t dut_rd();
      line_t v;
      for (int i = 0; i < LS; i++) v[i] = rd_line[i];
      return v;
   endfunction

   function automatic line_t rand_line();
      line_t v;
      for (int i = 0; i < LS; i++) v[i] = $urandom();
      return v;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every gnt must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst) begin
         prev_gnt = 1'b0;
      end else begin
         if (gnt) begin
            check("gnt_single", prev_gnt, 1'b0);
            check("gnt_pending", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("gnt_edge", cyc, e.done_edge);
               check("rd_line", dut_rd(), e.rd);
            end
         end
         prev_gnt = gnt;
      end
   end

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   // op: 0 read, 1 write, 2 both. ofs=1 when the DUT is idle, 2 when called on the gnt cycle.
   task automatic run_op(input int op, input logic [AL-1:0] a, input line_t l, input int unsigned ofs);
      exp_t e;
      bit   got;
      addr   = a;
      rd_req = (op != 1);
      wr_req = (op != 0);
      for (int i = 0; i < LS; i++) wr_line[i] = l[i];
      e.done_edge = cyc + ofs + LAT;
      if (op == 0) begin
         e.rd = mdl_mem[a];
      end else begin
         mdl_mem[a] = l;
         e.rd       = mdl_rd;
      end
      mdl_rd = e.rd;
      sb.push_back(e);
      got = 1'b0;
      for (int n = 0; n < LAT + 12 && !got; n++) begin
         @(negedge clk);
         if (gnt) begin
            got = 1'b1;
         end else if (n >= int'(ofs) - 1) begin
            addr = AL'($urandom());
            for (int i = 0; i < LS; i++) wr_line[i] = $urandom();
         end
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
      check("gnt_seen", got, 1'b1);
      if (!got && sb.size() != 0) void'(sb.pop_back());
   endtask

   task automatic abort_op(input int op, input logic [AL-1:0] a, input line_t l, input int hold);
      addr   = a;
      rd_req = (op == 0);
      wr_req = (op != 0);
      for (int i = 0; i < LS; i++) wr_line[i] = l[i];
      gap(hold);
      rd_req = 1'b0;
      wr_req = 1'b0;
      gap(LAT + 4);
      check("abort_rd_line", dut_rd(), mdl_rd);
   endtask

   task automatic reset_mid(input logic [AL-1:0] a, input line_t l);
      addr   = a;
      wr_req = 1'b1;
      for (int i = 0; i < LS; i++) wr_line[i] = l[i];
      gap(3);
      rst = 1'b1;
      #1;
      mdl_rd = '0;
      check("midrst_gnt", gnt, 1'b0);
      check("midrst_rd_line", dut_rd(), mdl_rd);
      @(negedge clk);
      wr_req = 1'b0;
      rst    = 1'b0;
   endtask

   initial begin
      line_t l5, la, lz;
      bool_t_dummy: begin end
      for (int i = 0; i < (1 << AL); i++) mdl_mem[i] = '0;
      mdl_rd = '0;
      for (int i = 0; i < LS; i++) wr_line[i] = '0;

      rst = 1'b1;
      gap(3);
      check("reset_gnt", gnt, 1'b0);
      check("reset_rd_line", dut_rd(), 128'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_gnt", gnt, 1'b0);
      end

      l5[0] = 32'h11111111; l5[1] = 32'h22222222;
      l5[2] = 32'h33333333; l5[3] = 32'h44444444;
      run_op(1, 7'h05, l5, 1);
      gap(2);
      run_op(0, 7'h05, rand_line(), 1);
      gap(3);
      check("rd_hold", dut_rd(), mdl_rd);

      la = rand_line();
      gap(2);
      run_op(1, 7'h7F, la, 1);
      run_op(0, 7'h03, rand_line(), 2);
      gap(2);
      check("rd_hold", dut_rd(), mdl_rd);
      run_op(0, 7'h7F, rand_line(), 1);

      gap(2);
      abort_op(0, 7'h05, rand_line(), 4);
      abort_op(1, 7'h05, rand_line(), 3);
      run_op(0, 7'h05, rand_line(), 1);

      gap(2);
      reset_mid(7'h10, rand_line());
      gap(1);
      run_op(0, 7'h10, rand_line(), 1);
      gap(2);
      run_op(0, 7'h05, rand_line(), 1);

      lz = rand_line();
      gap(2);
      run_op(2, 7'h20, lz, 1);
      gap(2);
      check("both_rd_hold", dut_rd(), mdl_rd);
      run_op(0, 7'h20, rand_line(), 1);

      begin
         bit at_gnt = 1'b1;
         for (int it = 0; it < 60; it++) begin
            logic [AL-1:0] ra;
            ra = AL'($urandom_range(0, (1 << AL) - 1));
            if ($urandom_range(0, 9) == 0) begin
               gap(2);
               abort_op($urandom_range(0, 1), ra, rand_line(), $urandom_range(1, LAT - 1));
               at_gnt = 1'b0;
            end else if (at_gnt && $urandom_range(0, 2) == 0) begin
               run_op($urandom_range(0, 2), ra, rand_line(), 2);
               at_gnt = 1'b1;
            end else begin
               gap($urandom_range(2, 4));
               check("rd_hold", dut_rd(), mdl_rd);
               run_op($urandom_range(0, 2), ra, rand_line(), 1);
               at_gnt = 1'b1;
            end
         end
      end

      gap(LAT + 4);
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
